// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared widths and helpers for the registered stream demux
package stream_demux_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_NUM_CH = 8;
    localparam int DEFAULT_ERR_W  = 16;

    // Select width that never collapses to zero bits, even for a two-channel build.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slice for a single demux channel
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // Occupancy: a load wins over a drain on the same edge so streaming has no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Payload only changes on load, so a stalled or empty slot keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/stream_demux_reg.sv
// rtl/stream_demux_reg.sv - 1-to-NUM_CH valid/ready demux with per-channel output registers
module stream_demux_reg
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int SEL_W  = clog2_min1(NUM_CH),
    parameter int ERR_W  = DEFAULT_ERR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [ERR_W-1:0]         drop_cnt
);

    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic              sel_legal;
    logic              sel_full;
    logic              sel_out_ready;
    logic              accept;
    logic              drop;

    // Selects past the last channel only exist when NUM_CH is not a power of two.
    generate
        if ((1 << SEL_W) == NUM_CH) begin : g_sel_full_range
            assign sel_legal = 1'b1;
        end else begin : g_sel_partial_range
            assign sel_legal = (in_sel < SEL_W'(NUM_CH));
        end
    endgenerate

    // One-hot decode of the destination channel; all zero for an illegal select.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    // Occupancy and sink readiness of the selected channel, without out-of-range indexing.
    always_comb begin
        sel_full      = 1'b0;
        sel_out_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_hit[k]) begin
                sel_full      = full[k];
                sel_out_ready = out_ready[k];
            end
        end
    end

    // A slot can take a beat when empty or when it drains on this same edge.
    assign in_ready = !sel_legal || !sel_full || sel_out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = {NUM_CH{accept && sel_legal}} & sel_hit;
    assign drain    = full & out_ready;
    assign drop     = in_valid && !sel_legal;

    // Saturating count of beats swallowed for an out-of-range select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {ERR_W{1'b1}})) begin
            drop_cnt <= drop_cnt + ERR_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            demux_slot #(
                .DATA_W(DATA_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .load     (load[k]),
                .load_data(in_data),
                .drain    (drain[k]),
                .full     (full[k]),
                .data     (slot_data[k])
            );
            assign out_data[k*DATA_W +: DATA_W] = slot_data[k];
        end
    endgenerate

    assign out_valid = full;

endmodule

// File: tb/tb_stream_demux_reg.sv
// tb/tb_stream_demux_reg.sv - self-checking bench for stream_demux_reg
module tb_stream_demux_reg;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic [15:0] drop_cnt;

    logic        s6_valid;
    logic [7:0]  s6_data;
    logic [2:0]  s6_sel;
    logic [5:0]  s6_out_ready;
    logic        s6a_ready;
    logic [5:0]  s6a_valid;
    logic [47:0] s6a_data;
    logic [15:0] s6a_drop;
    logic        s6b_ready;
    logic [5:0]  s6b_valid;
    logic [47:0] s6b_data;
    logic [1:0]  s6b_drop;

    int checks = 0;
    int errors = 0;

    logic       m_full [8];
    logic [7:0] m_data [8];
    logic       seen_ready;
    logic       exp_ready;

    always #5 clk = ~clk;

    stream_demux_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt)
    );

    stream_demux_reg #(.DATA_W(8), .NUM_CH(6), .ERR_W(16)) dut6a (
        .clk(clk), .rst(rst), .in_valid(s6_valid), .in_ready(s6a_ready),
        .in_data(s6_data), .in_sel(s6_sel), .out_valid(s6a_valid),
        .out_ready(s6_out_ready), .out_data(s6a_data), .drop_cnt(s6a_drop)
    );

    stream_demux_reg #(.DATA_W(8), .NUM_CH(6), .ERR_W(2)) dut6b (
        .clk(clk), .rst(rst), .in_valid(s6_valid), .in_ready(s6b_ready),
        .in_data(s6_data), .in_sel(s6_sel), .out_valid(s6b_valid),
        .out_ready(s6_out_ready), .out_data(s6b_data), .drop_cnt(s6b_drop)
    );

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
        end
    endtask

    function automatic logic [7:0] exp_valid_vec();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_full[k];
        return r;
    endfunction

    function automatic logic [63:0] exp_data_vec();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = m_data[k];
        return r;
    endfunction

    // One cycle on the 8-channel DUT: drive, sample in_ready mid-cycle, advance model at the edge.
    task automatic tick(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic [7:0] rdy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #4;
        seen_ready = in_ready;
        exp_ready  = !m_full[sel] || rdy[sel];
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (v && exp_ready && (int'(sel) == k)) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (m_full[k] && rdy[k]) begin
                m_full[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00;
        s6_valid = 1'b0; s6_sel = 3'd0; s6_data = 8'h00; s6_out_ready = 6'h3F;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h exp %h", out_valid, 8'h00); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp %h", out_data, 64'h0); end
        checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop got %h exp %h", drop_cnt, 16'h0); end
        rst = 1'b0;
        model_clear();
        s6_valid = 1'b1; s6_sel = 3'd7;
        tick(1'b1, 3'd2, 8'h22, 8'h00);
        tick(1'b1, 3'd5, 8'h55, 8'h00);
        s6_valid = 1'b0;
        checks++; if (out_valid !== 8'b0010_0100) begin errors++; $display("FAIL prereset_valid got %b exp %b", out_valid, 8'b0010_0100); end
        checks++; if (s6a_drop !== 16'd2) begin errors++; $display("FAIL prereset_drop got %0d exp %0d", s6a_drop, 2); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL async_reset_valid got %b exp %b", out_valid, 8'h00); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL async_reset_data got %h exp %h", out_data, 64'h0); end
        checks++; if (s6a_drop !== 16'd0) begin errors++; $display("FAIL async_reset_drop got %0d exp %0d", s6a_drop, 0); end
        checks++; if (s6b_drop !== 2'd0) begin errors++; $display("FAIL async_reset_drop_sat got %0d exp %0d", s6b_drop, 0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        tick(1'b1, 3'd3, 8'hA5, 8'hFF);
        checks++; if (out_valid !== 8'b0000_1000) begin errors++; $display("FAIL first_beat_valid got %b exp %b", out_valid, 8'b0000_1000); end
        checks++; if (out_data[31:24] !== 8'hA5) begin errors++; $display("FAIL first_beat_data got %h exp %h", out_data[31:24], 8'hA5); end
        tick(1'b0, 3'd0, 8'h00, 8'hFF);
    endtask

    task automatic test_fan_out();
        logic [7:0] onehot;
        for (int s = 0; s < 8; s++) begin
            tick(1'b1, 3'(s), 8'(8'h10 + s), 8'hFF);
            onehot = 8'h00;
            onehot[s] = 1'b1;
            checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL fanout_ready ch%0d got %b exp 1", s, seen_ready); end
            checks++; if (out_valid !== onehot) begin errors++; $display("FAIL fanout_valid ch%0d got %b exp %b", s, out_valid, onehot); end
            checks++; if (out_data[s*8 +: 8] !== 8'(8'h10 + s)) begin errors++; $display("FAIL fanout_data ch%0d got %h exp %h", s, out_data[s*8 +: 8], 8'(8'h10 + s)); end
        end
        tick(1'b0, 3'd0, 8'h00, 8'hFF);
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL fanout_idle got %b exp %b", out_valid, 8'h00); end
    endtask

    task automatic test_backpressure();
        tick(1'b1, 3'd2, 8'h11, 8'hFB);
        checks++; if (out_valid !== 8'b0000_0100 || out_data[23:16] !== 8'h11) begin errors++; $display("FAIL bp_first got %b/%h exp %b/%h", out_valid, out_data[23:16], 8'b0000_0100, 8'h11); end
        tick(1'b1, 3'd4, 8'h44, 8'hFB);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b exp 1", seen_ready); end
        checks++; if (out_valid !== 8'b0001_0100 || out_data[39:32] !== 8'h44) begin errors++; $display("FAIL bp_other_deliver got %b/%h exp %b/%h", out_valid, out_data[39:32], 8'b0001_0100, 8'h44); end
        tick(1'b1, 3'd2, 8'h22, 8'hFB);
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled_ready got %b exp 0", seen_ready); end
        checks++; if (out_valid !== 8'b0000_0100 || out_data[23:16] !== 8'h11) begin errors++; $display("FAIL bp_hold got %b/%h exp %b/%h", out_valid, out_data[23:16], 8'b0000_0100, 8'h11); end
        tick(1'b1, 3'd2, 8'h22, 8'hFF);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", seen_ready); end
        checks++; if (out_valid !== 8'b0000_0100 || out_data[23:16] !== 8'h22) begin errors++; $display("FAIL bp_second got %b/%h exp %b/%h", out_valid, out_data[23:16], 8'b0000_0100, 8'h22); end
        tick(1'b0, 3'd0, 8'h00, 8'hFF);
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL bp_idle got %b exp %b", out_valid, 8'h00); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 3'd1, 8'(i), 8'hFF);
            checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat%0d got %b exp 1", i, seen_ready); end
            checks++; if (out_valid !== 8'b0000_0010 || out_data[15:8] !== 8'(i)) begin errors++; $display("FAIL stream_out beat%0d got %b/%h exp %b/%h", i, out_valid, out_data[15:8], 8'b0000_0010, 8'(i)); end
        end
        tick(1'b0, 3'd0, 8'h00, 8'hFF);
    endtask

    task automatic test_load_drain();
        tick(1'b1, 3'd0, 8'hAA, 8'hFE);
        checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'hAA) begin errors++; $display("FAIL ld_fill got %b/%h exp 1/%h", out_valid[0], out_data[7:0], 8'hAA); end
        tick(1'b1, 3'd0, 8'hBB, 8'hFF);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b exp 1", seen_ready); end
        checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'hBB) begin errors++; $display("FAIL ld_replace got %b/%h exp 1/%h", out_valid[0], out_data[7:0], 8'hBB); end
        tick(1'b0, 3'd0, 8'h00, 8'hFF);
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL ld_idle got %b exp %b", out_valid, 8'h00); end
    endtask

    task automatic test_illegal();
        int ndrop;
        int sat;
        ndrop = 0;
        s6_out_ready = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            s6_valid = 1'b1;
            s6_sel   = (i % 2 == 1) ? 3'd7 : 3'd6;
            s6_data  = 8'($urandom);
            #4;
            checks++; if (s6a_ready !== 1'b1 || s6b_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready drop%0d got %b%b exp 11", i, s6a_ready, s6b_ready); end
            @(posedge clk);
            #1;
            ndrop++;
            sat = (ndrop > 3) ? 3 : ndrop;
            checks++; if (s6a_valid !== 6'h00 || s6b_valid !== 6'h00) begin errors++; $display("FAIL illegal_no_valid drop%0d got %b/%b exp 0", i, s6a_valid, s6b_valid); end
            checks++; if (s6a_drop !== 16'(ndrop)) begin errors++; $display("FAIL illegal_count drop%0d got %0d exp %0d", i, s6a_drop, ndrop); end
            checks++; if (s6b_drop !== 2'(sat)) begin errors++; $display("FAIL illegal_sat drop%0d got %0d exp %0d", i, s6b_drop, sat); end
            if (i == 2) begin
                s6_valid = 1'b0;
                s6_sel   = 3'd7;
                @(posedge clk);
                #1;
                checks++; if (s6a_drop !== 16'd3) begin errors++; $display("FAIL illegal_idle_hold got %0d exp %0d", s6a_drop, 3); end
            end
        end
        s6_valid = 1'b1;
        s6_sel   = 3'd5;
        s6_data  = 8'h5A;
        @(posedge clk);
        #1;
        s6_valid = 1'b0;
        checks++; if (s6a_valid !== 6'b10_0000 || s6a_data[47:40] !== 8'h5A) begin errors++; $display("FAIL legal6_deliver got %b/%h exp %b/%h", s6a_valid, s6a_data[47:40], 6'b10_0000, 8'h5A); end
        checks++; if (s6a_drop !== 16'd5) begin errors++; $display("FAIL legal6_no_drop got %0d exp %0d", s6a_drop, 5); end
    endtask

    task automatic test_random();
        logic [7:0] ev;
        logic [63:0] ed;
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            ev = exp_valid_vec();
            ed = exp_data_vec();
            checks++; if (seen_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc%0d got %b exp %b", c, seen_ready, exp_ready); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rand_valid cyc%0d got %b exp %b", c, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL rand_data cyc%0d got %h exp %h", c, out_data, ed); end
        end
        checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rand_drop got %0d exp 0", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_fan_out();
        test_backpressure();
        test_streaming();
        test_load_drain();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_reg.md
Name: stream_demux_reg

Overview:
- Parametrised successor to the team's 1-to-8 combinational demux.
- Routes a valid/ready data stream from one source to one of NUM_CH sink channels, selected per beat by in_sel.
- Each channel has a one-entry output register, so a stalled sink does not block beats bound for other channels.
- Out-of-range selects are consumed, dropped and counted.
- Sits between a shared producer, such as a packet parser, and per-lane consumers.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- NUM_CH, 8, number of output channels (2..64; need not be a power of two).
- SEL_W, $clog2(NUM_CH), select width (derived; do not override).
- ERR_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  source beat valid.
- in_ready  output  1  demux can accept the beat this cycle.
- in_data  input  DATA_W  source payload.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NUM_CH  per-channel valid; bit k belongs to channel k.
- out_ready  input  NUM_CH  per-channel sink ready.
- out_data  output  NUM_CH*DATA_W  flattened payloads; channel k occupies [k*DATA_W +: DATA_W].
- drop_cnt  output  ERR_W  count of beats dropped for an out-of-range in_sel; saturating.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - All slot full flags = 0, so out_valid = 0.
  - out_data = 0.
  - drop_cnt = 0.
  - Reset mid-transfer discards any held beats with no output glitch beyond the clear.
- Per-channel slot k holds full[k] and data[k]. out_valid[k] = full[k]; out_data slice k = data[k].
- Legal select: in_sel < NUM_CH.
  - in_ready = !full[in_sel] || out_ready[in_sel].
  - in_ready is combinational from in_sel and out_ready. This is the only input-to-output combinational path.
- Illegal select: in_sel >= NUM_CH (only possible when NUM_CH is not a power of two).
  - in_ready = 1.
  - The beat is consumed and no slot changes.
  - drop_cnt increments by 1 and saturates at 2^ERR_W-1 (no wrap).
- Accept: in_valid && in_ready. For a legal select, the next edge sets full[in_sel] = 1 and data[in_sel] = in_data.
- Drain: out_valid[k] && out_ready[k]. The next edge clears full[k], unless the same edge also loads slot k.
- Simultaneous drain and load on slot k: full[k] stays 1, data[k] takes the new beat. This gives back-to-back throughput of 1 beat/cycle per channel with no bubble.
- Latency: a beat accepted at edge n is visible on out_valid/out_data after edge n.
- Ordering:
  - Within a channel, order is preserved (single entry, no reordering possible).
  - Across channels there is no ordering guarantee; sinks drain independently.
- When in_valid = 0, in_ready may take any value and no state changes, except drains.
- out_data slice k is held stable while full[k] && !out_ready[k] (AXI-style stability).
- The slot register updates only on load, so when empty the slice retains its last value.
- in_data and in_sel are ignored when no handshake occurs.
- No X propagation: when in_valid = 0 and in_sel is out-of-range, drop_cnt does not change.

Decomposition:
- Shared package stream_demux_pkg holds:
  - the function clog2_min1 (returns at least 1, for NUM_CH = 2 corner safety);
  - the localparam default widths.
- One natural sub-module, demux_slot: a one-entry register slice with inputs load, load_data and drain, and outputs full and data.
  - The top generates NUM_CH instances.
  - The top contains the select decode, in_ready mux and drop counter.
- Target size is roughly 150–250 lines total.

Test Plan:
- Reset check: assert rst mid-stream with slots 2 and 5 full.
  - Required: out_valid = 0 and drop_cnt = 0 immediately (asynchronous).
  - Required: after release, first beat (sel = 3, data = 0xA5) appears on channel 3 one cycle after accept.
- Fan-out: send sel = 0..7 with data = 0x10+sel, all out_ready = 1.
  - Required: each out_valid[k] pulses for exactly one cycle with data 0x10+k.
  - Required: in_ready stays 1 throughout.
- Back-pressure isolation: out_ready[2] = 0. Send sel = 2 (0x11), then sel = 2 (0x22), then sel = 4 (0x44).
  - Required: first beat held on channel 2.
  - Required: in_ready = 0 while the second sel = 2 beat is presented; after out_ready[2] rises, the second beat is accepted the same cycle.
  - Required: the sel = 4 beat is accepted and delivered while channel 2 is stalled, if presented first.
- Bubble-free streaming: channel 1, 10 consecutive beats 0x00..0x09, out_ready[1] = 1.
  - Required: in_ready = 1 every cycle.
  - Required: outputs appear one per cycle in order.
- Illegal select: NUM_CH = 6, send sel = 6 and sel = 7, three beats total.
  - Required: in_ready = 1, no out_valid asserts, drop_cnt = 3.
  - Required: with ERR_W = 2, five drops leave drop_cnt saturated at 3.
- Simultaneous load and drain on channel 0: slot full, out_ready[0] = 1, new beat 0xBB.
  - Required: out_valid[0] stays 1 and the next cycle shows 0xBB.
